// File: rtl/data_bus_responder_if.sv
// Core data-side bus: byte address, store data/strobe, combinational read data.
interface data_bus_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport master (output Address, output WriteData, output MemWrite, input ReadData);
  modport slave  (input Address, input WriteData, input MemWrite, output ReadData);
endinterface

// File: rtl/data_bus_responder.sv
// Data-side responder: word RAM below Address[22], IO (LEDs, cycle counter,
// buffered 8N1 UART transmitter) above it.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_bus_responder_if.slave   bus,
  output logic                  uart_tx,
  output logic [7:0]            leds
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic          io_sel, wr_ram, wr_io;
  logic [2:0]    io_reg;
  logic [AW-1:0] ram_idx;
  logic          wr_leds, push_req, wr_status, wr_cycle;
  logic          unused_addr;

  assign io_sel    = bus.Address[22];
  assign io_reg    = bus.Address[4:2];
  assign ram_idx   = bus.Address[AW+1:2];
  assign wr_ram    = bus.MemWrite && !io_sel;
  assign wr_io     = bus.MemWrite && io_sel;
  assign wr_leds   = wr_io && (io_reg == 3'd0);
  assign push_req  = wr_io && (io_reg == 3'd1);
  assign wr_status = wr_io && (io_reg == 3'd2);
  assign wr_cycle  = wr_io && (io_reg == 3'd3);
  // Upper address bits are don't-care: RAM aliases, IO decodes only [4:2].
  assign unused_addr = ^bus.Address;

  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= bus.WriteData;
  end

  logic [31:0] cycle_cnt;
  logic        overflow;
  logic [3:0]  count;
  logic        full, push_ok, pop, busy;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  assign full    = (count == 4'(FIFO_DEPTH));
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      leds      <= '0;
      cycle_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_leds) leds <= bus.WriteData[7:0];
      cycle_cnt <= wr_cycle ? '0 : cycle_cnt + 32'd1;
      if (wr_status)
        overflow <= 1'b0;
      else if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  uart_state_t   state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, baud_end;

  assign baud_end = (baud == BAUD_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      uart_tx <= tx_n;
    end
  end

  // tx_n is the level for the cycle after the edge, so the line stays registered.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = uart_tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr];
          baud_n  = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (count != '0) begin
            pop     = 1'b1;
            shreg_n = fifo_mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    case (io_reg)
      3'd0:    io_rdata = {24'b0, leds};
      3'd2:    io_rdata = {24'b0, count, overflow, busy, full};
      3'd3:    io_rdata = cycle_cnt;
      default: io_rdata = '0;
    endcase
    bus.ReadData = io_sel ? io_rdata : ram[ram_idx];
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboarded bench for data_bus_responder: bus reads/writes plus a UART
// line monitor that decodes frames and pops expected bytes.
module tb_data_bus_responder;
  localparam int unsigned B = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_tx;
  logic [7:0] leds;

  data_bus_responder_if bus();

  data_bus_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .BAUD_DIV(B)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .uart_tx(uart_tx), .leds(leds)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];
  int          gap_q[$];
  int          mon_idx = -1;
  int          idle_run = 0;

  always @(posedge clk) cyc++;

  // UART line monitor, sampling 2ns after each rising edge.
  initial begin : uart_mon
    logic [7:0] sh;
    logic       bad;
    logic [7:0] expb;
    int         bp;
    sh = '0; bad = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (resetn !== 1'b1) begin
        mon_idx = -1; idle_run = 0;
      end else begin
        if (mon_idx < 0 && uart_tx === 1'b0) begin
          gap_q.push_back(idle_run);
          idle_run = 0; mon_idx = 0; sh = '0; bad = 1'b0;
        end
        if (mon_idx < 0) idle_run++;
        else begin
          bp = mon_idx / B;
          if (bp == 0) begin
            if (uart_tx !== 1'b0) bad = 1'b1;
          end else if (bp <= 8) begin
            if (mon_idx % B == 0) sh[bp-1] = uart_tx;
            else if (uart_tx !== sh[bp-1]) bad = 1'b1;
          end else if (uart_tx !== 1'b1) bad = 1'b1;
          if (mon_idx == 10*B - 1) begin
            checks++;
            if (bad) begin
              failures++;
              $display("FAIL uart_frame_format: bad start/bit/stop timing, got bad=1 required bad=0");
            end
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL uart_byte: got %02h, required no frame", sh);
            end else begin
              expb = exp_q.pop_front();
              if (sh !== expb) begin
                failures++;
                $display("FAIL uart_byte: got %02h, required %02h", sh, expb);
              end
            end
            mon_idx = -1;
          end else mon_idx++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a; bus.WriteData = d; bus.MemWrite = 1'b1;
    @(posedge clk); #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a; bus.MemWrite = 1'b0;
    #1;
    d = bus.ReadData;
  endtask

  task automatic wait_drain(input int maxc, output logic ok);
    int n = 0;
    while ((exp_q.size() != 0 || mon_idx >= 0) && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    ok = (exp_q.size() == 0 && mon_idx < 0);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    resetn = 1'b1; bus.Address = '0; bus.WriteData = '0; bus.MemWrite = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checks++; if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds: got %02h required 00", leds); end
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b required 1", uart_tx); end
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status: got %08h required 00000000", d); end
    tick(2);
    bus_read(32'h0040_000C, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_cycle: got %08h required 00000000", d); end
    resetn = 1'b1;
    tick(1);
    bus_read(32'h0040_000C, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL cycle_after_release: got %08h required 00000001", d); end
  endtask

  task automatic test_ram;
    logic [31:0] d;
    logic [31:0] pat;
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_store: got %08h required deadbeef", d); end
    bus_write(32'h0000_1010, 32'hCAFE_F00D);
    bus_read(32'h0000_0010, d);
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_alias: got %08h required cafef00d", d); end
    bus_read(32'h0000_0013, d);
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_byte_offset: got %08h required cafef00d", d); end
    for (int i = 0; i < 4; i++) bus_write(32'h100 + 32'(i*4), 32'h1111_1111 * 32'(i+1) ^ 32'h8000_0001);
    bus_write(32'h0000_0FFC, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      pat = 32'h1111_1111 * 32'(i+1) ^ 32'h8000_0001;
      bus_read(32'h100 + 32'(i*4), d);
      checks++; if (d !== pat) begin failures++; $display("FAIL ram_word%0d: got %08h required %08h", i, d, pat); end
    end
    bus_read(32'h0000_0FFC, d);
    checks++; if (d !== 32'h0BAD_F00D) begin failures++; $display("FAIL ram_last_word: got %08h required 0badf00d", d); end
    bus_write(32'h0040_0010, 32'hFFFF_FFFF);
    bus_read(32'h0000_0010, d);
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL io_write_hits_ram: got %08h required cafef00d", d); end
    bus_read(32'h0040_0010, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL io_reserved_write: got %08h required 00000000", d); end
  endtask

  task automatic test_leds;
    logic [31:0] d;
    logic [31:0] offs [5];
    offs = '{32'h04, 32'h10, 32'h14, 32'h18, 32'h1C};
    bus_write(32'h0040_0000, 32'h1234_56A5);
    checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_out: got %02h required a5", leds); end
    bus_read(32'h0040_0000, d);
    checks++; if (d !== 32'h0000_00A5) begin failures++; $display("FAIL leds_read: got %08h required 000000a5", d); end
    for (int i = 0; i < 5; i++) begin
      bus_read(32'h0040_0000 | offs[i], d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL io_zero_off%02h: got %08h required 00000000", offs[i], d); end
    end
  endtask

  task automatic test_cycle;
    logic [31:0] c1, c2, d;
    bus_read(32'h0040_000C, c1);
    tick(5);
    bus_read(32'h0040_000C, c2);
    checks++; if (c2 - c1 !== 32'd5) begin failures++; $display("FAIL cycle_delta: got %0d required 5", c2 - c1); end
    bus_write(32'h0040_000C, 32'h1234_5678);
    bus_read(32'h0040_000C, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL cycle_clear: got %08h required 00000000", d); end
    tick(1);
    bus_read(32'h0040_000C, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL cycle_after_clear: got %08h required 00000001", d); end
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    bus_read(32'h0040_000C, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycle_forced: got %08h required ffffffff", d); end
    release dut.cycle_cnt;
    tick(1);
    bus_read(32'h0040_000C, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL cycle_wrap: got %08h required 00000000", d); end
  endtask

  task automatic test_uart_single;
    logic [31:0] d;
    logic        low_bad;
    logic        ok;
    low_bad = 1'b0;
    exp_q.push_back(8'hA5);
    bus_write(32'h0040_0004, 32'hFFFF_FFA5);
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h08) begin failures++; $display("FAIL uart_status_queued: got %08h required 00000008", d); end
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (k <= 4 && uart_tx !== 1'b0) low_bad = 1'b1;
      if (k == 1) begin
        bus_read(32'h0040_0008, d);
        checks++; if (d !== 32'h02) begin failures++; $display("FAIL uart_status_popped: got %08h required 00000002", d); end
      end
      if (k == 40) begin
        bus_read(32'h0040_0008, d);
        checks++; if (d[1] !== 1'b1) begin failures++; $display("FAIL uart_busy_last: got %b required 1", d[1]); end
      end
      if (k == 41) begin
        bus_read(32'h0040_0008, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL uart_idle_after: got %08h required 00000000", d); end
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL uart_tx_idle: got %b required 1", uart_tx); end
      end
    end
    checks++; if (low_bad) begin failures++; $display("FAIL uart_start_bit: got high during N+1..N+4 required low"); end
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL uart_single_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int unsigned n0;
    int          nz;
    logic        ok;
    gap_q.delete();
    n0 = 0;
    bus.Address = 32'h0040_0004; bus.MemWrite = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.WriteData = 32'h30 + 32'(i);
      if (i < 9) exp_q.push_back(8'(32'h30 + 32'(i)));
      @(posedge clk); #1;
      if (i == 0) n0 = cyc;
    end
    bus.MemWrite = 1'b0;
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h47) begin failures++; $display("FAIL ovf_status: got %08h required 00000047", d); end
    bus_write(32'h0040_0008, 32'h0);
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h43) begin failures++; $display("FAIL ovf_cleared: got %08h required 00000043", d); end
    while (cyc < n0 + 40) begin @(posedge clk); #1; end
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h43) begin failures++; $display("FAIL full_before_pop: got %08h required 00000043", d); end
    tick(1);
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h3A) begin failures++; $display("FAIL after_second_pop: got %08h required 0000003a", d); end
    wait_drain(9*10*B + 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_drain: got %0d pending required 0", exp_q.size()); end
    nz = 0;
    for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 0) nz++;
    checks++; if (gap_q.size() != 9 || nz != 0) begin
      failures++; $display("FAIL burst_gaps: got frames=%0d idle_gaps=%0d required frames=9 idle_gaps=0", gap_q.size(), nz);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    logic        hi_bad;
    logic        ok;
    hi_bad = 1'b0;
    bus_write(32'h0040_0000, 32'h5A);
    bus.Address = 32'h0040_0004; bus.MemWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.WriteData = 32'h61 + 32'(i);
      @(posedge clk); #1;
    end
    bus.MemWrite = 1'b0;
    tick(B + 3);
    resetn = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx: got %b required 1", uart_tx); end
    checks++; if (leds !== 8'h00) begin failures++; $display("FAIL rst_mid_leds: got %02h required 00", leds); end
    bus_read(32'h0040_0008, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_status: got %08h required 00000000", d); end
    tick(2);
    resetn = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) hi_bad = 1'b1;
    end
    checks++; if (hi_bad) begin failures++; $display("FAIL rst_mid_quiet: got tx low after release required high"); end
    exp_q.push_back(8'h3C);
    bus_write(32'h0040_0004, 32'h3C);
    wait_drain(10*B + 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid_resume: got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_leds;
    test_cycle;
    test_uart_single;
    test_back_to_back;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
